// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the WISC fetch stage: FSM states and ISA opcodes.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_WAIT   = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_e;

  localparam logic [4:0]  HALT_OPC = 5'b00000;
  localparam logic [15:0] NOP_OPC  = 16'h0800;

  // True when the opcode field (instr[15:11]) encodes HALT
  function automatic logic is_halt(input logic [4:0] opc);
    return opc == HALT_OPC;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: async reset, redirect load, +2 advance.
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_load_pc,
  input  logic        i_inc,
  output logic [15:0] o_pc
);

  logic [15:0] r_pc;

  // Load has priority over increment; increment wraps modulo 2^16
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_pc;
    else if (i_inc)  r_pc <= r_pc + 16'd2;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// WISC instruction-fetch stage: owns PC and imem handshake, handles
// multi-cycle memory, freeze buffering, redirects, halt and error.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_OPC,
  parameter int          TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        freeze,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        imem_stall,
  output logic [15:0] instr_F,
  output logic [15:0] inc_PC_F,
  output logic        instr_valid_F,
  output logic        fd_clr,
  output logic        halted,
  output logic        err
);

  localparam logic [3:0] TO = 4'(TIMEOUT);

  fetch_state_e r_state, w_state_nxt;
  logic         r_drop, w_drop_nxt;
  logic [3:0]   r_cnt, w_cnt_nxt;
  logic         r_err, w_err_nxt;
  logic [15:0]  r_buf, w_buf_nxt;
  logic         w_pc_load, w_pc_inc;
  logic [15:0]  w_pc;
  logic         w_timeout;

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_pc_load),
    .i_load_pc (redirect_pc),
    .i_inc     (w_pc_inc),
    .o_pc      (w_pc)
  );

  // Next WAIT cycle would be the TIMEOUT-th without a completion
  assign w_timeout = (r_cnt + 4'd1) == TO;

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_drop  <= 1'b0;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
      r_buf   <= NOP_INSTR;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  // Next-state and handshake outputs; redirect overrides everything except err-halt
  always_comb begin
    w_state_nxt   = r_state;
    w_drop_nxt    = r_drop;
    w_cnt_nxt     = r_cnt;
    w_err_nxt     = r_err;
    w_buf_nxt     = r_buf;
    w_pc_load     = 1'b0;
    w_pc_inc      = 1'b0;
    imem_req      = 1'b0;
    instr_F       = NOP_INSTR;
    instr_valid_F = 1'b0;
    fd_clr        = 1'b0;
    if (rst_n) begin
      if (redirect && !r_err) begin
        fd_clr    = 1'b1;
        w_pc_load = 1'b1;
        if (redirect_pc[0]) begin
          w_err_nxt   = 1'b1;
          w_drop_nxt  = 1'b0;
          w_state_nxt = S_HALTED;
        end else if (r_state == S_WAIT) begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (imem_done) begin
            // request retires this cycle, nothing left to drop
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_FETCH;
          end else if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_HALTED;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_FETCH;
        end
      end else begin
        unique case (r_state)
          S_FETCH: begin
            if (!freeze && !imem_stall) begin
              imem_req = 1'b1;
              if (imem_done) begin
                instr_valid_F = 1'b1;
                instr_F       = imem_rdata;
                w_pc_inc      = 1'b1;
                if (is_halt(imem_rdata[15:11])) w_state_nxt = S_HALTED;
              end else begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = S_WAIT;
              end
            end
          end
          S_WAIT: begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (imem_done) begin
              if (r_drop) begin
                w_drop_nxt  = 1'b0;
                w_state_nxt = S_FETCH;
              end else if (freeze) begin
                w_buf_nxt   = imem_rdata;
                w_state_nxt = S_HOLD;
              end else begin
                instr_valid_F = 1'b1;
                instr_F       = imem_rdata;
                w_pc_inc      = 1'b1;
                w_state_nxt   = is_halt(imem_rdata[15:11]) ? S_HALTED : S_FETCH;
              end
            end else if (w_timeout) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_HALTED;
            end
          end
          S_HOLD: begin
            instr_valid_F = 1'b1;
            instr_F       = r_buf;
            if (!freeze) begin
              w_pc_inc    = 1'b1;
              w_state_nxt = is_halt(r_buf[15:11]) ? S_HALTED : S_FETCH;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_addr = w_pc;
  assign inc_PC_F  = w_pc + 16'd2;
  assign halted    = (r_state == S_HALTED);
  assign err       = r_err;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// memory latency / freeze / stall / redirect against an accepted-stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, redirect, imem_done, imem_stall;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_req, instr_valid_F, fd_clr, halted, err;
  logic [15:0] imem_addr, instr_F, inc_PC_F;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_done(imem_done), .imem_stall(imem_stall),
    .instr_F(instr_F), .inc_PC_F(inc_PC_F), .instr_valid_F(instr_valid_F),
    .fd_clr(fd_clr), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // Memory image used by the random test; bit 15 set so it never decodes as HALT
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a ^ 16'h5A3C) | 16'h8000;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; freeze = 0; redirect = 0; redirect_pc = 0;
    imem_done = 0; imem_rdata = 0; imem_stall = 0;
    #3;
    checks++;
    if ({imem_req, instr_valid_F, fd_clr, halted, err} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=00000", {imem_req, instr_valid_F, fd_clr, halted, err});
    end
    checks++;
    if ({instr_F, imem_addr} !== {16'h0800, 16'h0000}) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0800/0000", instr_F, imem_addr);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_zero_wait();
    do_reset();
    imem_done = 1; imem_rdata = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({imem_req, instr_valid_F, imem_addr, inc_PC_F, instr_F} !==
          {2'b11, 16'(2*i), 16'(2*i+2), 16'h1234}) begin
        failures++; $display("FAIL zero_wait[%0d] got=%b %b %h %h %h", i, imem_req, instr_valid_F, imem_addr, inc_PC_F, instr_F);
      end
      tick();
    end
    redirect = 1; redirect_pc = 16'hFFFE;
    #1;
    checks++;
    if ({fd_clr, instr_valid_F, imem_req} !== 3'b100) begin
      failures++; $display("FAIL redirect_fetch got=%b exp=100", {fd_clr, instr_valid_F, imem_req});
    end
    tick();
    redirect = 0;
    #1;
    checks++;
    if ({imem_addr, inc_PC_F} !== {16'hFFFE, 16'h0000}) begin
      failures++; $display("FAIL wrap_inc got=%h/%h exp=fffe/0000", imem_addr, inc_PC_F);
    end
    tick(); #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL wrap_pc got=%b/%h exp=1/0000", imem_req, imem_addr);
    end
    imem_done = 0;
  endtask

  task automatic test_slow_mem();
    do_reset();
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      failures++; $display("FAIL slow_req0 got=%b/%h exp=1/0000", imem_req, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      checks++;
      if ({imem_req, instr_valid_F} !== 2'b00) begin
        failures++; $display("FAIL slow_wait[%0d] got=%b exp=00", i, {imem_req, instr_valid_F});
      end
    end
    tick();
    imem_done = 1; imem_rdata = 16'h4123;
    #1;
    checks++;
    if ({instr_valid_F, instr_F, inc_PC_F} !== {1'b1, 16'h4123, 16'h0002}) begin
      failures++; $display("FAIL slow_deliver got=%b %h %h exp=1 4123 0002", instr_valid_F, instr_F, inc_PC_F);
    end
    tick();
    imem_done = 0;
    #1;
    checks++;
    if ({instr_valid_F, imem_req, imem_addr} !== {2'b01, 16'h0002}) begin
      failures++; $display("FAIL slow_next got=%b %b %h exp=0 1 0002", instr_valid_F, imem_req, imem_addr);
    end
  endtask

  task automatic test_freeze_wait();
    do_reset();
    tick();                         // request at 0000 issued, now WAIT
    freeze = 1;
    tick();
    imem_done = 1; imem_rdata = 16'hC0FF;
    tick();
    imem_done = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({instr_valid_F, imem_req, instr_F} !== {2'b10, 16'hC0FF}) begin
        failures++; $display("FAIL hold[%0d] got=%b %b %h exp=1 0 c0ff", i, instr_valid_F, imem_req, instr_F);
      end
      tick();
    end
    freeze = 0;
    #1;
    checks++;
    if ({instr_valid_F, imem_req, instr_F, inc_PC_F} !== {2'b10, 16'hC0FF, 16'h0002}) begin
      failures++; $display("FAIL hold_release got=%b %b %h %h exp=1 0 c0ff 0002", instr_valid_F, imem_req, instr_F, inc_PC_F);
    end
    tick(); #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0002}) begin
      failures++; $display("FAIL hold_next got=%b/%h exp=1/0002", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    tick();                         // WAIT on 0000
    redirect = 1; redirect_pc = 16'h0040;
    #1;
    checks++;
    if ({fd_clr, instr_valid_F, imem_req} !== 3'b100) begin
      failures++; $display("FAIL redir_wait got=%b exp=100", {fd_clr, instr_valid_F, imem_req});
    end
    tick();
    redirect = 0; imem_done = 1; imem_rdata = 16'h1111;
    #1;
    checks++;
    if ({fd_clr, instr_valid_F, imem_req} !== 3'b000) begin
      failures++; $display("FAIL redir_drop got=%b exp=000", {fd_clr, instr_valid_F, imem_req});
    end
    tick();
    imem_done = 0;
    #1;
    checks++;
    if ({imem_req, imem_addr, fd_clr} !== {1'b1, 16'h0040, 1'b0}) begin
      failures++; $display("FAIL redir_next got=%b %h %b exp=1 0040 0", imem_req, imem_addr, fd_clr);
    end
  endtask

  task automatic test_halt();
    do_reset();
    redirect = 1; redirect_pc = 16'h0010;
    tick();
    redirect = 0; imem_done = 1; imem_rdata = 16'h0000;
    #1;
    checks++;
    if ({imem_req, imem_addr, instr_valid_F} !== {1'b1, 16'h0010, 1'b1}) begin
      failures++; $display("FAIL halt_fetch got=%b %h %b exp=1 0010 1", imem_req, imem_addr, instr_valid_F);
    end
    tick();
    imem_done = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({halted, imem_req} !== 2'b10) begin
        failures++; $display("FAIL halted[%0d] got=%b exp=10", i, {halted, imem_req});
      end
      tick();
    end
    redirect = 1; redirect_pc = 16'h0020;
    #1;
    checks++;
    if (fd_clr !== 1'b1) begin
      failures++; $display("FAIL halt_redir_clr got=%b exp=1", fd_clr);
    end
    tick();
    redirect = 0;
    #1;
    checks++;
    if ({halted, imem_req, imem_addr} !== {2'b01, 16'h0020}) begin
      failures++; $display("FAIL halt_resume got=%b %b %h exp=0 1 0020", halted, imem_req, imem_addr);
    end
  endtask

  task automatic test_err();
    do_reset();
    redirect = 1; redirect_pc = 16'h0031;
    tick();
    redirect = 0;
    #1;
    checks++;
    if ({err, halted} !== 2'b11) begin
      failures++; $display("FAIL misalign got=%b exp=11", {err, halted});
    end
    redirect = 1; redirect_pc = 16'h0020;
    #1;
    checks++;
    if (fd_clr !== 1'b0) begin
      failures++; $display("FAIL err_ignore_redir got=%b exp=0", fd_clr);
    end
    tick();
    redirect = 0;
    #1;
    checks++;
    if ({err, halted, imem_req} !== 3'b110) begin
      failures++; $display("FAIL err_sticky got=%b exp=110", {err, halted, imem_req});
    end
    do_reset();                      // checks err cleared while in reset
    repeat (10) tick();
    #1;
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL timeout_early got=%b exp=0", err);
    end
    repeat (10) tick();
    #1;
    checks++;
    if ({err, halted, imem_req} !== 3'b110) begin
      failures++; $display("FAIL timeout got=%b exp=110", {err, halted, imem_req});
    end
    rst_n = 0;
    #1;
    checks++;
    if ({err, halted} !== 2'b00) begin
      failures++; $display("FAIL err_reset got=%b exp=00", {err, halted});
    end
  endtask

  // Random memory latency and control noise; model: the accepted stream is
  // consecutive words from the last redirect target, each request at that PC
  task automatic test_random();
    logic [15:0] exp_pc, pend_addr;
    logic        pend;
    int          pend_left, accepted, lat;
    do_reset();
    exp_pc = 16'h0000; pend = 0; pend_left = 0; pend_addr = 0; accepted = 0;
    for (int c = 0; c < 1500; c++) begin
      freeze      = ($urandom % 4) == 0;
      imem_stall  = ($urandom % 5) == 0;
      redirect    = ($urandom % 20) == 0;
      redirect_pc = 16'($urandom) & 16'hFFFE;
      imem_done   = 0;
      #1;
      if (pend) begin
        checks++;
        if (imem_req !== 1'b0) begin
          failures++; $display("FAIL rnd_two_outstanding cyc=%0d got=%b exp=0", c, imem_req);
        end
        if (pend_left == 0) begin
          imem_done = 1; imem_rdata = memf(pend_addr); pend = 0;
        end else pend_left--;
      end else if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== exp_pc) begin
          failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h exp=%h", c, imem_addr, exp_pc);
        end
        lat = $urandom % 4;
        if (lat == 0) begin
          imem_done = 1; imem_rdata = memf(imem_addr);
        end else begin
          pend = 1; pend_left = lat - 1; pend_addr = imem_addr;
        end
      end
      #1;
      if (redirect) begin
        checks++;
        if ({fd_clr, instr_valid_F} !== 2'b10) begin
          failures++; $display("FAIL rnd_redirect cyc=%0d got=%b exp=10", c, {fd_clr, instr_valid_F});
        end
        exp_pc = redirect_pc;
      end else if (instr_valid_F && !freeze) begin
        accepted++;
        checks++;
        if ({instr_F, inc_PC_F, fd_clr} !== {memf(exp_pc), 16'(exp_pc + 16'd2), 1'b0}) begin
          failures++; $display("FAIL rnd_deliver cyc=%0d got=%h %h %b exp=%h %h 0", c, instr_F, inc_PC_F, fd_clr, memf(exp_pc), 16'(exp_pc + 16'd2));
        end
        exp_pc = exp_pc + 16'd2;
      end
      checks++;
      if ({err, halted} !== 2'b00) begin
        failures++; $display("FAIL rnd_no_err cyc=%0d got=%b exp=00", c, {err, halted});
      end
      tick();
    end
    checks++;
    if (accepted < 200) begin
      failures++; $display("FAIL rnd_throughput got=%0d exp>=200", accepted);
    end
    redirect = 0; freeze = 0; imem_stall = 0; imem_done = 0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_freeze_wait();
    test_redirect_wait();
    test_halt();
    test_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
